load_store_unit: RTL and testbench

- Memory-stage block directly downstream of the ALU. It takes the ALU result (SUM) as the effective address for loads and stores.
- Drives a single-port data-memory bus with a req/ready handshake and generates byte enables and lane-replicated write data.
- Extracts and sign- or zero-extends load data.
- Holds the pipeline with a stall signal while an access is outstanding.

---
 rtl/load_store_unit_pkg.sv | 44 ++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM state
// encoding and small decode helpers used by the top level.
package load_store_unit_pkg;

  localparam int LSU_XLEN = 32;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Stores have no unsigned variants, so BU/HU are legal only for loads.
  function automatic logic lsu_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      LSU_B, LSU_H, LSU_W: return 1'b1;
      LSU_BU, LSU_HU:      return !is_store;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_aligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return !a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lsu_byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it according to funct3.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [LSU_XLEN-1:0] i_rdata,
  input  logic [1:0]          i_lane,
  input  logic [2:0]          i_funct3,
  output logic [LSU_XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    case (i_funct3)
      LSU_B:   o_data = {{24{w_byte[7]}}, w_byte};
      LSU_BU:  o_data = {24'd0, w_byte};
      LSU_H:   o_data = {{16{w_half[15]}}, w_half};
      LSU_HU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues one data-memory access at a time over a
// req/ready bus, stalls the pipeline while it is outstanding, and returns loads.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_funct3,
  input  logic [DATA_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic                  flush,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  lsu_stall,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  access_err,
  output logic [1:0]            dbg_state
);

  // Bus handshake: dmem_req is high for every REQ cycle and address, byte
  // enables, write data and we stay frozen until the cycle dmem_ready is
  // high; that cycle completes the access. dmem_ready outside REQ is ignored.

  lsu_state_t            r_state;
  lsu_state_t            w_next_state;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [1:0]            r_lane;
  logic [2:0]            r_funct3;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_flushed;
  logic                  r_load_valid;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic                  r_access_err;

  logic                  w_is_access;
  logic                  w_open;
  logic                  w_ok;
  logic                  w_start;
  logic                  w_err;
  logic                  w_kill;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_align_data;

  assign w_is_access = mem_read | mem_write;
  assign w_open      = (r_state == IDLE) || (r_state == RESP);
  // mem_write wins when both are set, so legality is judged as a store.
  assign w_ok        = lsu_legal(mem_funct3, mem_write) &
                       lsu_aligned(mem_funct3[1:0], alu_addr[1:0]);
  assign w_start     = ex_valid & w_is_access & w_ok & !flush & w_open;
  assign w_err       = ex_valid & w_is_access & !w_ok & !flush & w_open;
  assign w_kill      = r_flushed | flush;
  assign w_be        = lsu_byte_en(mem_funct3[1:0], alu_addr[1:0]);

  always_comb begin
    case (mem_funct3[1:0])
      2'b00:   w_wdata = {4{store_data[7:0]}};
      2'b01:   w_wdata = {2{store_data[15:0]}};
      default: w_wdata = store_data;
    endcase
  end

  lsu_load_align u_align (
    .i_rdata  (dmem_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_funct3),
    .o_data   (w_align_data)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = REQ;
      REQ:     if (dmem_ready) w_next_state = RESP;
      RESP:    w_next_state = w_start ? REQ : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_lane       <= 2'b00;
      r_funct3     <= 3'b000;
      r_we         <= 1'b0;
      r_be         <= 4'b0000;
      r_wdata      <= '0;
      r_flushed    <= 1'b0;
      r_load_valid <= 1'b0;
      r_load_data  <= '0;
      r_access_err <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_access_err <= w_err;
      r_load_valid <= 1'b0;
      if (w_start) begin
        r_addr    <= {alu_addr[DATA_WIDTH-1:2], 2'b00};
        r_lane    <= alu_addr[1:0];
        r_funct3  <= mem_funct3;
        r_we      <= mem_write;
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_flushed <= 1'b0;
      end else if (r_state == REQ) begin
        if (flush) r_flushed <= 1'b1;
        // A flushed access still finishes on the bus but its data is dropped.
        if (dmem_ready && !r_we && !w_kill) begin
          r_load_valid <= 1'b1;
          r_load_data  <= w_align_data;
        end
      end
    end
  end

  assign dmem_req   = (r_state == REQ);
  assign dmem_we    = dmem_req & r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;
  assign lsu_stall  = w_start | (r_state == REQ);
  assign load_valid = r_load_valid;
  assign load_data  = r_load_data;
  assign access_err = r_access_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected bus beats and load results are
// queued at issue time and checked by an independent negedge monitor.
module tb_load_store_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid, mem_read, mem_write, flush;
  logic [2:0]   mem_funct3;
  logic [W-1:0] alu_addr, store_data;
  logic         dmem_req, dmem_we, dmem_ready;
  logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]   dmem_be;
  logic         lsu_stall, load_valid, access_err;
  logic [W-1:0] load_data;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_funct3(mem_funct3), .alu_addr(alu_addr),
    .store_data(store_data), .flush(flush), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .lsu_stall(lsu_stall), .load_valid(load_valid), .load_data(load_data),
    .access_err(access_err), .dbg_state(dbg_state)
  );

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [3:0]   be;
    logic [W-1:0] wdata;
    logic         chk_wd;
  } bus_t;

  bus_t         exp_bus_q[$];
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_mis = 0;
  int           err_seen = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bus_t b;
    if (dmem_req) begin
      if (exp_bus_q.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL bus_unexpected_req: got req addr 0x%08h expected no request", dmem_addr);
      end else begin
        b = exp_bus_q[0];
        check("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
        check("bus_addr", dmem_addr, b.addr);
        check("bus_be", {28'd0, dmem_be}, {28'd0, b.be});
        if (b.chk_wd) check("bus_wdata", dmem_wdata, b.wdata);
        check("req_stall", {31'd0, lsu_stall}, 32'd1);
        if (dmem_ready) void'(exp_bus_q.pop_front());
      end
    end
    if (load_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_mis++;
        $display("FAIL load_unexpected: got load_data 0x%08h expected no load_valid", load_data);
      end else begin
        check("load_data", load_data, exp_q.pop_front());
      end
    end
    if (access_err) err_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [W-1:0] a, input logic [W-1:0] sd);
    ex_valid = 1'b1; mem_read = rd; mem_write = wr;
    mem_funct3 = f3; alu_addr = a; store_data = sd;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic expect_bus(input logic we, input logic [W-1:0] a, input logic [3:0] be,
                            input logic [W-1:0] wd, input logic chk);
    bus_t b;
    b.we = we; b.addr = a; b.be = be; b.wdata = wd; b.chk_wd = chk;
    exp_bus_q.push_back(b);
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [W-1:0] a, input logic [W-1:0] sd,
                            input int wait_n, input logic [W-1:0] rdata,
                            input logic [W-1:0] exp_addr, input logic [3:0] exp_be,
                            input logic [W-1:0] exp_wd, input logic chk_wd,
                            input logic [W-1:0] exp_ld);
    expect_bus(wr, exp_addr, exp_be, exp_wd, chk_wd);
    if (!wr) exp_q.push_back(exp_ld);
    present(rd, wr, f3, a, sd);
    @(negedge clk);
    check("start_stall", {31'd0, lsu_stall}, 32'd1);
    check("start_no_req", {31'd0, dmem_req}, 32'd0);
    cyc();
    idle_ex();
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      check("wait_state", {30'd0, dbg_state}, 32'd1);
      cyc();
    end
    dmem_ready = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    cyc();
    dmem_ready = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    check("resp_req_low", {31'd0, dmem_req}, 32'd0);
    check("resp_stall_low", {31'd0, lsu_stall}, 32'd0);
    check("resp_load_valid", {31'd0, load_valid}, {31'd0, !wr});
    cyc();
  endtask

  task automatic err_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [W-1:0] a);
    present(rd, wr, f3, a, 32'h5555_AAAA);
    @(negedge clk);
    check("err_stall", {31'd0, lsu_stall}, 32'd0);
    check("err_no_req", {31'd0, dmem_req}, 32'd0);
    cyc();
    idle_ex();
    @(negedge clk);
    check("err_pulse", {31'd0, access_err}, 32'd1);
    check("err_no_req2", {31'd0, dmem_req}, 32'd0);
    check("err_state", {30'd0, dbg_state}, 32'd0);
    cyc();
    @(negedge clk);
    check("err_single", {31'd0, access_err}, 32'd0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    idle_ex(); mem_funct3 = 3'b000; alu_addr = '0; store_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_err", {31'd0, access_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // loads of every size/sign, then stores
    run_access(1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 0, 0, 32'hDEADBEEF);
    run_access(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF7F01, 32'h100, 4'b1000, 0, 0, 32'hFFFFFF80);
    run_access(1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF7F01, 32'h100, 4'b1000, 0, 0, 32'h00000080);
    run_access(1, 0, 3'b001, 32'h102, 0, 0, 32'h80FF7F01, 32'h100, 4'b1100, 0, 0, 32'hFFFF80FF);
    run_access(1, 0, 3'b101, 32'h100, 0, 2, 32'h1234F00D, 32'h100, 4'b0011, 0, 0, 32'h0000F00D);
    run_access(0, 1, 3'b001, 32'h206, 32'h1234ABCD, 3, 0, 32'h204, 4'b1100, 32'hABCDABCD, 1, 0);
    // read and write both set behaves as a store byte
    run_access(1, 1, 3'b000, 32'h101, 32'h000000EF, 0, 0, 32'h100, 4'b0010, 32'hEFEFEFEF, 1, 0);
    @(negedge clk);
    check("load_data_hold", load_data, 32'h0000F00D);
    cyc();

    err_access(1, 0, 3'b010, 32'h101);
    err_access(0, 1, 3'b100, 32'h200);
    err_access(1, 0, 3'b001, 32'h103);
    err_access(1, 1, 3'b101, 32'h100);

    // flush in IDLE blocks the start
    present(1, 0, 3'b010, 32'h100, 0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", {31'd0, lsu_stall}, 32'd0);
    cyc();
    idle_ex(); flush = 1'b0;
    @(negedge clk);
    check("flush_idle_req", {31'd0, dmem_req}, 32'd0);
    check("flush_idle_err", {31'd0, access_err}, 32'd0);
    cyc();

    // flush during REQ: bus completes, load dropped
    expect_bus(0, 32'h104, 4'b1111, 0, 0);
    present(1, 0, 3'b010, 32'h104, 0);
    @(negedge clk);
    cyc();
    idle_ex(); flush = 1'b1;
    @(negedge clk);
    check("flush_req_held", {31'd0, dmem_req}, 32'd1);
    cyc();
    flush = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h11111111;
    @(negedge clk);
    cyc();
    dmem_ready = 1'b0;
    @(negedge clk);
    check("flush_no_valid", {31'd0, load_valid}, 32'd0);
    check("flush_data_kept", load_data, 32'h0000F00D);
    cyc();

    // back-to-back: SW issued in the RESP cycle of a LW
    expect_bus(0, 32'h108, 4'b1111, 0, 0);
    exp_q.push_back(32'h0BADF00D);
    present(1, 0, 3'b010, 32'h108, 0);
    @(negedge clk);
    cyc();
    idle_ex(); dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    cyc();
    dmem_ready = 1'b0;
    expect_bus(1, 32'h300, 4'b1111, 32'hCAFEF00D, 1);
    present(0, 1, 3'b010, 32'h300, 32'hCAFEF00D);
    @(negedge clk);
    check("b2b_resp_state", {30'd0, dbg_state}, 32'd2);
    check("b2b_stall", {31'd0, lsu_stall}, 32'd1);
    cyc();
    idle_ex(); dmem_ready = 1'b1;
    @(negedge clk);
    check("b2b_req_now", {31'd0, dmem_req}, 32'd1);
    check("b2b_state", {30'd0, dbg_state}, 32'd1);
    cyc();
    dmem_ready = 1'b0;
    @(negedge clk);
    check("b2b_done_req", {31'd0, dmem_req}, 32'd0);
    check("b2b_no_valid", {31'd0, load_valid}, 32'd0);
    cyc();

    // reset in the middle of REQ
    expect_bus(0, 32'h10C, 4'b1111, 0, 0);
    present(1, 0, 3'b010, 32'h10C, 0);
    @(negedge clk);
    cyc();
    idle_ex();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    check("rst_mid_stall", {31'd0, lsu_stall}, 32'd0);
    exp_bus_q.delete();
    cyc();
    rst = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h77777777;
    @(negedge clk);
    check("late_ready_req", {31'd0, dmem_req}, 32'd0);
    cyc();
    dmem_ready = 1'b0;
    @(negedge clk);
    check("late_ready_valid", {31'd0, load_valid}, 32'd0);
    check("late_ready_state", {30'd0, dbg_state}, 32'd0);
    cyc();

    check("err_count", err_seen, 32'd4);
    check("load_q_empty", exp_q.size(), 32'd0);
    check("bus_q_empty", exp_bus_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
